// File: rtl/alu_ctrl_issue_stage_pkg.sv
// Shared encodings for the multi-lane ALU control issue stage: opcode/funct values,
// ALU control codes and the per-lane decode record.
package alu_ctrl_issue_stage_pkg;

    localparam int OPCODE_WIDTH = 6;
    localparam int FUNCT_WIDTH  = 6;
    localparam int ALU_CONTROL  = 5;

    typedef logic [OPCODE_WIDTH-1:0] opcode_t;
    typedef logic [FUNCT_WIDTH-1:0]  funct_t;
    typedef logic [ALU_CONTROL-1:0]  aluc_t;

    localparam opcode_t OP_RTYPE = 6'h00;
    localparam opcode_t OP_ADDI  = 6'h08;
    localparam opcode_t OP_ADDIU = 6'h09;
    localparam opcode_t OP_SLTI  = 6'h0A;
    localparam opcode_t OP_SLTIU = 6'h0B;
    localparam opcode_t OP_ANDI  = 6'h0C;
    localparam opcode_t OP_ORI   = 6'h0D;
    localparam opcode_t OP_XORI  = 6'h0E;
    localparam opcode_t OP_LUI   = 6'h0F;
    localparam opcode_t OP_LB    = 6'h20;
    localparam opcode_t OP_LH    = 6'h21;
    localparam opcode_t OP_LW    = 6'h23;
    localparam opcode_t OP_LBU   = 6'h24;
    localparam opcode_t OP_LHU   = 6'h25;
    localparam opcode_t OP_SB    = 6'h28;
    localparam opcode_t OP_SH    = 6'h29;
    localparam opcode_t OP_SW    = 6'h2B;

    localparam funct_t F_SLL  = 6'h00;
    localparam funct_t F_SRL  = 6'h02;
    localparam funct_t F_SRA  = 6'h03;
    localparam funct_t F_JR   = 6'h08;
    localparam funct_t F_ADD  = 6'h20;
    localparam funct_t F_ADDU = 6'h21;
    localparam funct_t F_SUB  = 6'h22;
    localparam funct_t F_SUBU = 6'h23;
    localparam funct_t F_AND  = 6'h24;
    localparam funct_t F_OR   = 6'h25;
    localparam funct_t F_XOR  = 6'h26;
    localparam funct_t F_NOR  = 6'h27;
    localparam funct_t F_SLT  = 6'h2A;
    localparam funct_t F_SLTU = 6'h2B;
    localparam funct_t F_EQ   = 6'h2C;
    localparam funct_t F_NEQ  = 6'h2D;
    localparam funct_t F_GE   = 6'h2E;
    localparam funct_t F_GEU  = 6'h2F;

    localparam aluc_t ALUC_ADD  = 5'd0;
    localparam aluc_t ALUC_SUB  = 5'd1;
    localparam aluc_t ALUC_AND  = 5'd2;
    localparam aluc_t ALUC_OR   = 5'd3;
    localparam aluc_t ALUC_NOR  = 5'd4;
    localparam aluc_t ALUC_SLT  = 5'd5;
    localparam aluc_t ALUC_SLTU = 5'd6;
    localparam aluc_t ALUC_SLL  = 5'd7;
    localparam aluc_t ALUC_SRL  = 5'd8;
    localparam aluc_t ALUC_SRA  = 5'd9;
    localparam aluc_t ALUC_EQ   = 5'd10;
    localparam aluc_t ALUC_NEQ  = 5'd11;
    localparam aluc_t ALUC_GE   = 5'd12;
    localparam aluc_t ALUC_GEU  = 5'd13;
    localparam aluc_t ALUC_ADDU = 5'd14;
    localparam aluc_t ALUC_XOR  = 5'd15;
    localparam aluc_t ALUC_SUBU = 5'd17;
    localparam aluc_t ALUC_LUI  = 5'd18;
    localparam aluc_t ALUC_JR   = 5'd19;

    typedef struct packed {
        aluc_t control;
        logic  uses_alu;
        logic  illegal;
    } lane_dec_t;

endpackage

// File: rtl/alu_ctrl_lane_dec.sv
// Single-lane ALU control decode, purely combinational; an invalid lane decodes to all zeros.
// Latency 0, no handshake of its own.
module alu_ctrl_lane_dec
    import alu_ctrl_issue_stage_pkg::*;
(
    input  logic                    lane_vld,
    input  logic [OPCODE_WIDTH-1:0] opcode,
    input  logic [FUNCT_WIDTH-1:0]  funct,
    output lane_dec_t               dec
);

    always_comb begin
        dec = '0;
        case (opcode)
            OP_RTYPE: begin
                dec.uses_alu = 1'b1;
                case (funct)
                    F_ADD:   dec.control = ALUC_ADD;
                    F_SUB:   dec.control = ALUC_SUB;
                    F_AND:   dec.control = ALUC_AND;
                    F_OR:    dec.control = ALUC_OR;
                    F_NOR:   dec.control = ALUC_NOR;
                    F_SLT:   dec.control = ALUC_SLT;
                    F_SLTU:  dec.control = ALUC_SLTU;
                    F_SLL:   dec.control = ALUC_SLL;
                    F_SRL:   dec.control = ALUC_SRL;
                    F_SRA:   dec.control = ALUC_SRA;
                    F_EQ:    dec.control = ALUC_EQ;
                    F_NEQ:   dec.control = ALUC_NEQ;
                    F_GE:    dec.control = ALUC_GE;
                    F_GEU:   dec.control = ALUC_GEU;
                    F_ADDU:  dec.control = ALUC_ADDU;
                    F_XOR:   dec.control = ALUC_XOR;
                    F_SUBU:  dec.control = ALUC_SUBU;
                    F_JR:    dec.control = ALUC_JR;
                    default: dec.illegal = 1'b1;
                endcase
            end
            OP_ADDI:  begin dec.uses_alu = 1'b1; dec.control = ALUC_ADD;  end
            OP_ADDIU: begin dec.uses_alu = 1'b1; dec.control = ALUC_ADDU; end
            OP_SLTI:  begin dec.uses_alu = 1'b1; dec.control = ALUC_SLT;  end
            OP_SLTIU: begin dec.uses_alu = 1'b1; dec.control = ALUC_SLTU; end
            OP_ANDI:  begin dec.uses_alu = 1'b1; dec.control = ALUC_AND;  end
            OP_ORI:   begin dec.uses_alu = 1'b1; dec.control = ALUC_OR;   end
            OP_XORI:  begin dec.uses_alu = 1'b1; dec.control = ALUC_XOR;  end
            OP_LUI:   begin dec.uses_alu = 1'b1; dec.control = ALUC_LUI;  end
            // Memory ops use the ALU for address generation.
            OP_LW, OP_LB, OP_LH, OP_LBU, OP_LHU, OP_SW, OP_SB, OP_SH: begin
                dec.uses_alu = 1'b1;
                dec.control  = ALUC_ADD;
            end
            default: dec = '0;
        endcase
        if (!lane_vld) begin
            dec = '0;
        end
    end

endmodule

// File: rtl/alu_ctrl_issue_stage.sv
// Multi-lane ALU control decode between superscalar decode and issue, with a saturating illegal count.
// Latency 1 cycle from accept to output valid; main + skid registers keep full throughput.
// Ready is ~skid_full from a flop, so downstream ready never reaches upstream combinationally.
module alu_ctrl_issue_stage
    import alu_ctrl_issue_stage_pkg::*;
#(
    parameter int ISSUE_WIDTH = 2,
    parameter int CNT_WIDTH   = 8
) (
    input  logic                              acs_i_clk,
    input  logic                              acs_i_rst_n,
    input  logic                              acs_i_flush,
    input  logic                              acs_i_valid,
    output logic                              acs_o_ready,
    input  logic [ISSUE_WIDTH-1:0]            acs_i_lane_vld,
    input  logic [ISSUE_WIDTH*OPCODE_WIDTH-1:0] acs_i_opcode,
    input  logic [ISSUE_WIDTH*FUNCT_WIDTH-1:0]  acs_i_funct,
    output logic                              acs_o_valid,
    input  logic                              acs_i_ready,
    output logic [ISSUE_WIDTH-1:0]            acs_o_lane_vld,
    output logic [ISSUE_WIDTH*ALU_CONTROL-1:0] acs_o_control,
    output logic [ISSUE_WIDTH-1:0]            acs_o_uses_alu,
    output logic [ISSUE_WIDTH-1:0]            acs_o_illegal,
    output logic [CNT_WIDTH-1:0]              acs_o_ill_cnt
);

    localparam int SUM_W = CNT_WIDTH + 3;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    typedef struct packed {
        logic [ISSUE_WIDTH-1:0]             lane_vld;
        logic [ISSUE_WIDTH*ALU_CONTROL-1:0] control;
        logic [ISSUE_WIDTH-1:0]             uses_alu;
        logic [ISSUE_WIDTH-1:0]             illegal;
    } bundle_t;

    lane_dec_t                          lane_dec [ISSUE_WIDTH];
    logic [ISSUE_WIDTH*ALU_CONTROL-1:0] in_ctrl;
    logic [ISSUE_WIDTH-1:0]             in_uses;
    logic [ISSUE_WIDTH-1:0]             in_ill;
    bundle_t                            in_bun;

    bundle_t                main_q;
    bundle_t                skid_q;
    logic                   main_vld;
    logic                   skid_vld;
    logic [CNT_WIDTH-1:0]   ill_cnt;
    logic [SUM_W-1:0]       ill_sum;
    logic [CNT_WIDTH-1:0]   cnt_nxt;
    logic                   accept;
    logic                   deliver;

    for (genvar k = 0; k < ISSUE_WIDTH; k++) begin : g_lane
        alu_ctrl_lane_dec u_dec (
            .lane_vld (acs_i_lane_vld[k]),
            .opcode   (acs_i_opcode[k*OPCODE_WIDTH +: OPCODE_WIDTH]),
            .funct    (acs_i_funct[k*FUNCT_WIDTH +: FUNCT_WIDTH]),
            .dec      (lane_dec[k])
        );
        assign in_ctrl[k*ALU_CONTROL +: ALU_CONTROL] = lane_dec[k].control;
        assign in_uses[k] = lane_dec[k].uses_alu;
        assign in_ill[k]  = lane_dec[k].illegal;
    end

    assign in_bun = '{lane_vld: acs_i_lane_vld, control: in_ctrl, uses_alu: in_uses, illegal: in_ill};

    assign accept  = acs_i_valid & ~skid_vld;
    assign deliver = main_vld & acs_i_ready;

    always_ff @(posedge acs_i_clk or negedge acs_i_rst_n) begin
        if (!acs_i_rst_n) begin
            main_vld <= 1'b0;
            skid_vld <= 1'b0;
            main_q   <= '0;
            skid_q   <= '0;
        end else if (acs_i_flush) begin
            main_vld <= 1'b0;
            skid_vld <= 1'b0;
        end else if (deliver) begin
            // Skid is drained first; ready was low, so no accept can coincide with it.
            if (skid_vld) begin
                main_q   <= skid_q;
                skid_vld <= 1'b0;
            end else if (accept) begin
                main_q   <= in_bun;
            end else begin
                main_vld <= 1'b0;
            end
        end else if (accept) begin
            if (main_vld) begin
                skid_q   <= in_bun;
                skid_vld <= 1'b1;
            end else begin
                main_q   <= in_bun;
                main_vld <= 1'b1;
            end
        end
    end

    always_comb begin
        ill_sum = SUM_W'(ill_cnt);
        for (int k = 0; k < ISSUE_WIDTH; k++) begin
            ill_sum = ill_sum + SUM_W'(main_q.illegal[k] & main_q.lane_vld[k]);
        end
        cnt_nxt = (ill_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : ill_sum[CNT_WIDTH-1:0];
    end

    // Flush deliberately leaves the count alone; only reset clears it.
    always_ff @(posedge acs_i_clk or negedge acs_i_rst_n) begin
        if (!acs_i_rst_n) begin
            ill_cnt <= '0;
        end else if (deliver && !acs_i_flush) begin
            ill_cnt <= cnt_nxt;
        end
    end

    assign acs_o_ready    = ~skid_vld;
    assign acs_o_valid    = main_vld;
    assign acs_o_lane_vld = main_q.lane_vld;
    assign acs_o_control  = main_q.control;
    assign acs_o_uses_alu = main_q.uses_alu;
    assign acs_o_illegal  = main_q.illegal;
    assign acs_o_ill_cnt  = ill_cnt;

endmodule

// File: tb/tb_alu_ctrl_issue_stage.sv
// Bench for alu_ctrl_issue_stage: scoreboarded 2-lane instance plus a 3-lane / 2-bit-counter instance.
module tb_alu_ctrl_issue_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        i_valid = 1'b0;
    logic        o_ready;
    logic [1:0]  i_lv = '0;
    logic [11:0] i_op = '0;
    logic [11:0] i_fn = '0;
    logic        o_valid;
    logic        i_ready = 1'b0;
    logic [1:0]  o_lv;
    logic [9:0]  o_ctrl;
    logic [1:0]  o_uses;
    logic [1:0]  o_ill;
    logic [7:0]  o_cnt;

    logic        rst_n3 = 1'b0;
    logic        flush3 = 1'b0;
    logic        valid3 = 1'b0;
    logic        ready3;
    logic [2:0]  lv3 = '0;
    logic [17:0] op3 = '0;
    logic [17:0] fn3 = '0;
    logic        o_valid3;
    logic        i_ready3 = 1'b0;
    logic [2:0]  o_lv3;
    logic [14:0] o_ctrl3;
    logic [2:0]  o_uses3;
    logic [2:0]  o_ill3;
    logic [1:0]  o_cnt3;

    always #5 clk = ~clk;

    alu_ctrl_issue_stage #(.ISSUE_WIDTH(2), .CNT_WIDTH(8)) u_dut (
        .acs_i_clk(clk), .acs_i_rst_n(rst_n), .acs_i_flush(flush), .acs_i_valid(i_valid),
        .acs_o_ready(o_ready), .acs_i_lane_vld(i_lv), .acs_i_opcode(i_op), .acs_i_funct(i_fn),
        .acs_o_valid(o_valid), .acs_i_ready(i_ready), .acs_o_lane_vld(o_lv), .acs_o_control(o_ctrl),
        .acs_o_uses_alu(o_uses), .acs_o_illegal(o_ill), .acs_o_ill_cnt(o_cnt)
    );

    alu_ctrl_issue_stage #(.ISSUE_WIDTH(3), .CNT_WIDTH(2)) u_dut3 (
        .acs_i_clk(clk), .acs_i_rst_n(rst_n3), .acs_i_flush(flush3), .acs_i_valid(valid3),
        .acs_o_ready(ready3), .acs_i_lane_vld(lv3), .acs_i_opcode(op3), .acs_i_funct(fn3),
        .acs_o_valid(o_valid3), .acs_i_ready(i_ready3), .acs_o_lane_vld(o_lv3), .acs_o_control(o_ctrl3),
        .acs_o_uses_alu(o_uses3), .acs_o_illegal(o_ill3), .acs_o_ill_cnt(o_cnt3)
    );

    typedef struct packed {
        logic [1:0] lv;
        logic [9:0] ctrl;
        logic [1:0] uses;
        logic [1:0] ill;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [7:0]  exp_cnt = '0;
    bit          prev_hold = 1'b0;
    logic [16:0] prev_out = '0;
    bit          rand_done = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference decode: {control[4:0], uses_alu, illegal}
    function automatic logic [6:0] lane_model(logic lv, logic [5:0] op, logic [5:0] fn);
        logic [4:0] c = 5'd0;
        logic       u = 1'b0;
        logic       il = 1'b0;
        if (op == 6'h00) begin
            u = 1'b1;
            case (fn)
                6'h20: c = 5'd0;   6'h22: c = 5'd1;   6'h24: c = 5'd2;   6'h25: c = 5'd3;
                6'h27: c = 5'd4;   6'h2A: c = 5'd5;   6'h2B: c = 5'd6;   6'h00: c = 5'd7;
                6'h02: c = 5'd8;   6'h03: c = 5'd9;   6'h2C: c = 5'd10;  6'h2D: c = 5'd11;
                6'h2E: c = 5'd12;  6'h2F: c = 5'd13;  6'h21: c = 5'd14;  6'h26: c = 5'd15;
                6'h23: c = 5'd17;  6'h08: c = 5'd19;
                default: il = 1'b1;
            endcase
        end else begin
            case (op)
                6'h08: begin u = 1'b1; c = 5'd0;  end
                6'h09: begin u = 1'b1; c = 5'd14; end
                6'h0A: begin u = 1'b1; c = 5'd5;  end
                6'h0B: begin u = 1'b1; c = 5'd6;  end
                6'h0C: begin u = 1'b1; c = 5'd2;  end
                6'h0D: begin u = 1'b1; c = 5'd3;  end
                6'h0E: begin u = 1'b1; c = 5'd15; end
                6'h0F: begin u = 1'b1; c = 5'd18; end
                6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B: u = 1'b1;
                default: u = 1'b0;
            endcase
        end
        if (!lv) return 7'd0;
        return {c, u, il};
    endfunction

    function automatic exp_t bundle_model(logic [1:0] lv, logic [11:0] op, logic [11:0] fn);
        exp_t       e;
        logic [6:0] r;
        e.lv = lv;
        for (int k = 0; k < 2; k++) begin
            r = lane_model(lv[k], op[k*6 +: 6], fn[k*6 +: 6]);
            e.ctrl[k*5 +: 5] = r[6:2];
            e.uses[k] = r[1];
            e.ill[k]  = r[0];
        end
        return e;
    endfunction

    // Called just after a rising edge; returns just after the edge that took the bundle.
    task automatic send(input logic [1:0] lv, input logic [11:0] op, input logic [11:0] fn);
        bit acc = 1'b0;
        i_valid = 1'b1;
        i_lv = lv;
        i_op = op;
        i_fn = fn;
        for (int c = 0; c < 200 && !acc; c++) begin
            @(negedge clk);
            if (o_ready || flush) begin
                acc = 1'b1;
                if (!flush) sb.push_back(bundle_model(lv, op, fn));
            end
        end
        if (!acc) check_eq("send_timeout", 32'(acc), 32'd1);
        @(posedge clk);
        #1;
        i_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        exp_t e;
        int   t;
        if (rst_n) begin
            check_eq("ill_cnt", 32'(o_cnt), 32'(exp_cnt));
            if (prev_hold) check_eq("hold_stable", 32'({o_valid, o_lv, o_ctrl, o_uses, o_ill}), 32'(prev_out));
            if (flush) begin
                sb.delete();
                prev_hold = 1'b0;
            end else begin
                if (o_valid && i_ready) begin
                    if (sb.size() == 0) begin
                        check_eq("unexpected_out", 32'(sb.size()), 32'd1);
                    end else begin
                        e = sb.pop_front();
                        check_eq("out_lane_vld", 32'(o_lv), 32'(e.lv));
                        check_eq("out_control", 32'(o_ctrl), 32'(e.ctrl));
                        check_eq("out_uses_alu", 32'(o_uses), 32'(e.uses));
                        check_eq("out_illegal", 32'(o_ill), 32'(e.ill));
                        t = int'(exp_cnt) + $countones(e.ill & e.lv);
                        exp_cnt = (t > 255) ? 8'd255 : 8'(t);
                    end
                end
                prev_hold = o_valid && !i_ready;
                prev_out  = {o_valid, o_lv, o_ctrl, o_uses, o_ill};
            end
        end
    end

    task automatic send3(input logic [2:0] lv, input logic [17:0] op, input logic [17:0] fn);
        @(posedge clk);
        #1;
        valid3 = 1'b1;
        lv3 = lv;
        op3 = op;
        fn3 = fn;
        @(negedge clk);
        check_eq("d3_ready", 32'(ready3), 32'd1);
        @(posedge clk);
        #1;
        valid3 = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

    logic [5:0] ops [16] = '{6'h00, 6'h00, 6'h00, 6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C,
                             6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h20};
    logic [5:0] fns [21] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03,
                             6'h2C, 6'h2D, 6'h2E, 6'h2F, 6'h21, 6'h26, 6'h23, 6'h08, 6'h3F, 6'h01, 6'h15};

    initial begin
        logic [7:0] c0;
        // Reset state
        #3;
        check_eq("rst_valid", 32'(o_valid), 32'd0);
        check_eq("rst_ready", 32'(o_ready), 32'd1);
        check_eq("rst_outs", 32'({o_lv, o_ctrl, o_uses, o_ill}), 32'd0);
        check_eq("rst_cnt", 32'(o_cnt), 32'd0);
        #9;
        rst_n = 1'b1;
        rst_n3 = 1'b1;

        // 1: {ADD, ORI}
        @(posedge clk); #1;
        i_ready = 1'b1;
        send(2'b11, {6'h0D, 6'h00}, {6'h00, 6'h20});
        @(negedge clk);
        check_eq("t1_valid", 32'(o_valid), 32'd1);
        check_eq("t1_control", 32'(o_ctrl), 32'({5'd3, 5'd0}));
        check_eq("t1_uses", 32'(o_uses), 32'b11);
        check_eq("t1_illegal", 32'(o_ill), 32'b00);
        @(negedge clk);
        check_eq("t1_valid_one_cycle", 32'(o_valid), 32'd0);

        // 2: backpressure, A = {AND, SUB}, B = {SLT, XORI}
        @(posedge clk); #1;
        i_ready = 1'b0;
        send(2'b11, 12'h000, {6'h22, 6'h24});
        send(2'b11, {6'h0E, 6'h00}, {6'h00, 6'h2A});
        @(negedge clk);
        check_eq("t2_ready_low", 32'(o_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("t2_hold_valid", 32'(o_valid), 32'd1);
            check_eq("t2_hold_ctrl", 32'(o_ctrl), 32'({5'd1, 5'd2}));
        end
        @(posedge clk); #1;
        i_ready = 1'b1;
        @(negedge clk);
        check_eq("t2_a_valid", 32'(o_valid), 32'd1);
        check_eq("t2_a_ctrl", 32'(o_ctrl), 32'({5'd1, 5'd2}));
        @(negedge clk);
        check_eq("t2_b_valid", 32'(o_valid), 32'd1);
        check_eq("t2_b_ctrl", 32'(o_ctrl), 32'({5'd15, 5'd5}));
        check_eq("t2_ready_back", 32'(o_ready), 32'd1);
        @(negedge clk);
        check_eq("t2_drained", 32'(o_valid), 32'd0);

        // 3: illegal funct in lane1
        @(posedge clk); #1;
        c0 = exp_cnt;
        send(2'b11, 12'h000, {6'h3F, 6'h20});
        @(negedge clk);
        check_eq("t3_illegal", 32'(o_ill), 32'b10);
        check_eq("t3_ctrl_lane1", 32'(o_ctrl[9:5]), 32'd0);
        @(negedge clk);
        check_eq("t3_cnt_inc", 32'(o_cnt), 32'(c0 + 8'd1));
        @(posedge clk); #1;
        send(2'b01, 12'h000, {6'h3F, 6'h20});
        @(negedge clk);
        check_eq("t3_masked_illegal", 32'(o_ill), 32'b00);
        @(negedge clk);
        check_eq("t3_cnt_same", 32'(o_cnt), 32'(c0 + 8'd1));

        // 5: flush with main and skid full
        @(posedge clk); #1;
        i_ready = 1'b0;
        c0 = exp_cnt;
        send(2'b11, 12'h000, {6'h3F, 6'h3F});
        send(2'b11, 12'h000, {6'h3F, 6'h3F});
        @(negedge clk);
        check_eq("t5_full", 32'(o_ready), 32'd0);
        @(posedge clk); #1;
        flush = 1'b1;
        i_valid = 1'b1;
        i_ready = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        flush = 1'b0;
        i_valid = 1'b0;
        @(negedge clk);
        check_eq("t5_valid", 32'(o_valid), 32'd0);
        check_eq("t5_ready", 32'(o_ready), 32'd1);
        check_eq("t5_cnt", 32'(o_cnt), 32'(c0));
        @(negedge clk);
        check_eq("t5_no_ghost", 32'(o_valid), 32'd0);

        // Random bundles under random backpressure
        @(posedge clk); #1;
        fork
            begin
                for (int n = 0; n < 80; n++) begin
                    logic [1:0]  lv;
                    logic [11:0] op;
                    logic [11:0] fn;
                    lv = 2'($urandom_range(0, 3));
                    op = {ops[$urandom_range(0, 15)], ops[$urandom_range(0, 15)]};
                    fn = {fns[$urandom_range(0, 20)], fns[$urandom_range(0, 20)]};
                    send(lv, op, fn);
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk); #1;
                    i_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        i_ready = 1'b1;
        repeat (5) @(negedge clk);
        check_eq("drain_empty", 32'(sb.size()), 32'd0);

        // 4: 2-bit counter saturates
        i_ready3 = 1'b1;
        send3(3'b001, 18'h0, {6'h3F, 6'h3F, 6'h3F});
        check_eq("t4_cnt1", 32'(o_cnt3), 32'd1);
        send3(3'b011, 18'h0, {6'h3F, 6'h3F, 6'h3F});
        check_eq("t4_cnt3", 32'(o_cnt3), 32'd3);
        send3(3'b011, 18'h0, {6'h3F, 6'h3F, 6'h3F});
        check_eq("t4_cnt_sat", 32'(o_cnt3), 32'd3);

        // 6: BEQ, LUI, SW held, then async reset
        @(posedge clk); #1;
        i_ready3 = 1'b0;
        valid3 = 1'b1;
        lv3 = 3'b111;
        op3 = {6'h2B, 6'h0F, 6'h04};
        fn3 = 18'h0;
        @(posedge clk); #1;
        valid3 = 1'b0;
        @(negedge clk);
        check_eq("t6_valid", 32'(o_valid3), 32'd1);
        check_eq("t6_control", 32'(o_ctrl3), 32'({5'd0, 5'd18, 5'd0}));
        check_eq("t6_uses", 32'(o_uses3), 32'b110);
        check_eq("t6_illegal", 32'(o_ill3), 32'b000);
        @(negedge clk);
        #2;
        rst_n3 = 1'b0;
        #1;
        check_eq("t6_arst_valid", 32'(o_valid3), 32'd0);
        check_eq("t6_arst_outs", 32'({o_lv3, o_ctrl3, o_uses3, o_ill3}), 32'd0);
        check_eq("t6_arst_cnt", 32'(o_cnt3), 32'd0);
        check_eq("t6_arst_ready", 32'(ready3), 32'd1);
        #1;
        rst_n3 = 1'b1;
        repeat (2) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
